tt_sweep_checker: RTL and testbench
===================================

// Module: tt_sweep_checker
// PURPOSE
//  - Parametrised, self-checking truth-table sweeper for N-input, 1-output combinational DUTs.
//  - Drives all 2^N_IN input vectors in ascending order and holds each for HOLD_CYCLES clocks.
//  - Samples the DUT output and compares it against an expected truth table.
//  - Reports error count, first failing vector and pass/done status.
//  - Sits beside the DUT in lab benches and on-board self-test wrappers.
// PARAMETERS
//  - N_IN         4          number of DUT inputs; legal range 1..8
//  - HOLD_CYCLES  20         clocks each vector is held; must be >= 1
//  - EXP_TABLE    16'h0000   expected output; bit k = expected f for input vector k; width 2**N_IN
// PORTS
//  - clk        in   1          single clock; all state updates on posedge
//  - rst        in   1          synchronous, active-high reset
//  - start      in   1          1-cycle pulse; begins a sweep when not busy
//  - dut_f      in   1          DUT output under test
//  - vec_out    out  N_IN       vector driven to DUT inputs; MSB = first DUT input (a)
//  - busy       out  1          high while a sweep is in progress
//  - done       out  1          high from end of sweep until next accepted start or rst
//  - pass       out  1          valid when done; 1 iff err_count == 0
//  - err_count  out  N_IN+1     number of mismatching vectors (max 2^N_IN, cannot overflow)
//  - fail_vec   out  N_IN       first mismatching vector; 0 if none
//  - fail_seen  out  1          1 once any mismatch has been recorded in the current sweep
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; every output listed above = 0; hold counter = 0.
//  - FSM states: IDLE, DRIVE, DONE.
//    - IDLE -> DRIVE on start.
//    - DRIVE -> DRIVE on vector advance.
//    - DRIVE -> DONE after the last vector is sampled.
//    - DONE -> DRIVE on start.
//  - Start accepted at edge T (in IDLE or DONE):
//    - Next state DRIVE; vec_out=0, hold_cnt=0, busy=1.
//    - done=0, pass=0, err_count=0, fail_vec=0, fail_seen=0.
//  - DRIVE: hold_cnt increments each clock.
//    - When hold_cnt == HOLD_CYCLES-1, dut_f is compared with EXP_TABLE[vec_out] at that edge.
//    - On mismatch: err_count+1; if fail_seen==0, fail_vec<=vec_out and fail_seen<=1.
//    - Same edge: hold_cnt<=0 and vec_out<=vec_out+1.
//    - If vec_out was all-ones: next state DONE, busy<=0, done<=1, pass<=(final err_count==0).
//    - vec_out stays at all-ones in DONE; no wrap to 0.
//  - Latency: done rises at edge T + 2^N_IN*HOLD_CYCLES (N_IN=4, HOLD=20: T+320).
//  - Each vector is driven for exactly HOLD_CYCLES clocks.
//  - start while busy is ignored; the sweep is unaffected.
//  - rst mid-sweep: aborts immediately to reset values; the next start runs a full clean sweep.
//  - rst and start in the same cycle: rst wins.
//  - HOLD_CYCLES=1: one sample per clock, no idle gap between vectors.
// CONFIGURATION
//  - Macro TT_SWEEP_CAPTURE_EN:
//    - Defined: adds port captured out 2**N_IN; bit k <= dut_f at the sample edge of vector k.
//      Cleared to 0 on rst and on accepted start; retained in DONE.
//    - Undefined: port and register absent; all other behaviour identical.
// STRUCTURE
//  - Shared header tt_sweep_defs.vh holds:
//    - state encodings TT_IDLE=2'd0, TT_DRIVE=2'd1, TT_DONE=2'd2;
//    - helper macro for hold-counter width, $clog2(HOLD_CYCLES) min 1.
//  - One natural sub-module, tt_hold_counter: HOLD_CYCLES-modulo counter with a last-cycle strobe.
//  - FSM, compare and result registers stay in the top.
// TESTING (N_IN=4, HOLD_CYCLES=20 unless stated)
//  - Correct DUT: DUT model f=EXP_TABLE[vec], EXP_TABLE=16'hA5C3, start pulse.
//    -> vec_out steps 0..15, 20 clk each; done at T+320; pass=1, err_count=0, fail_seen=0.
//  - Inverted DUT: f=~EXP_TABLE[vec].
//    -> err_count=16, fail_vec=0, fail_seen=1, pass=0.
//  - Single-minterm fault: DUT wrong only at vec 4'b1010.
//    -> err_count=1, fail_vec=10, pass=0.
//  - rst mid-sweep: rst pulse while vec_out=5; then start.
//    -> all outputs 0 the cycle after rst; second sweep completes with the correct-DUT results.
//  - start while busy: start re-pulsed at vec 7.
//    -> ignored; done still at T+320.
//    Also N_IN=2, HOLD_CYCLES=1: done at T+4.
//  - TT_SWEEP_CAPTURE_EN defined, correct DUT.
//    -> captured==16'hA5C3 at done; captured==0 after next start.

Source files
------------

// File: rtl/tt_sweep_checker_pkg.sv
// Shared FSM encodings and hold-counter width helper for the truth-table sweeper.
package tt_sweep_checker_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_DRIVE = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  // A hold of one clock still needs a 1-bit counter so the port widths stay legal.
  function automatic int hold_cnt_w(input int hold_cycles);
    return (hold_cycles <= 1) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/tt_sweep_checker_hold_counter.sv
// Modulo-HOLD_CYCLES counter; last_o is high combinationally while the count sits on HOLD_CYCLES-1.
// Latency: count updates one clock after en_i; no backpressure, clr_i overrides en_i.
module tt_hold_counter
  import tt_sweep_checker_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = hold_cnt_w(HOLD_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2^N_IN vectors (HOLD_CYCLES clocks each), scores dut_f_i against EXP_TABLE; done 2^N_IN*HOLD_CYCLES clocks after start.
// No backpressure: start_i is ignored while busy. TT_SWEEP_CAPTURE_EN adds captured_o (observed truth table).
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int                     N_IN        = 4,
  parameter int                     HOLD_CYCLES = 20,
  parameter logic [(1<<N_IN)-1:0]   EXP_TABLE   = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              dut_f_i,
  output logic [N_IN-1:0]   vec_out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [N_IN:0]     err_count_o,
  output logic [N_IN-1:0]   fail_vec_o,
`ifdef TT_SWEEP_CAPTURE_EN
  output logic              fail_seen_o,
  output logic [(1<<N_IN)-1:0] captured_o
`else
  output logic              fail_seen_o
`endif
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;

  tt_state_e         state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic              fail_seen_q, fail_seen_d;

  logic              hold_last;
  logic              start_acc;
  logic              sample_stb;
  logic              mismatch;
  logic [N_IN:0]     err_inc;

  assign start_acc  = start_i && (state_q != TT_DRIVE);
  assign sample_stb = (state_q == TT_DRIVE) && hold_last;

  tt_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_acc),
    .en_i   (state_q == TT_DRIVE),
    .last_o (hold_last)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    fail_seen_d = fail_seen_q;
    mismatch    = 1'b0;
    err_inc     = err_q;

    case (state_q)
      TT_IDLE, TT_DONE: begin
        if (start_acc) begin
          state_d     = TT_DRIVE;
          vec_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          fail_vec_d  = '0;
          fail_seen_d = 1'b0;
        end
      end
      TT_DRIVE: begin
        if (sample_stb) begin
          mismatch = (dut_f_i != EXP_TABLE[vec_q]);
          err_inc  = err_q + {{N_IN{1'b0}}, mismatch};
          err_d    = err_inc;
          if (mismatch && !fail_seen_q) begin
            fail_vec_d  = vec_q;
            fail_seen_d = 1'b1;
          end
          // Last vector: park on all-ones rather than wrapping back to 0.
          if (vec_q == VEC_MAX) begin
            state_d = TT_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == '0);
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: state_d = TT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= TT_IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign vec_out_o   = vec_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_vec_o  = fail_vec_q;
  assign fail_seen_o = fail_seen_q;

`ifdef TT_SWEEP_CAPTURE_EN
  logic [(1<<N_IN)-1:0] cap_q, cap_d;

  always_comb begin
    cap_d = cap_q;
    if (start_acc) begin
      cap_d = '0;
    end else if (sample_stb) begin
      cap_d[vec_q] = dut_f_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign captured_o = cap_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: table of DUT fault modes on a 4-input/20-hold sweeper plus reset/restart corner sequences
// and a 2-input/1-hold instance for the no-gap case.
module tb_tt_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 4-input, 20-clock hold instance
  logic [15:0] exp_tbl = 16'hA5C3;
  int          mode    = 0;
  logic        start   = 1'b0;
  logic        dut_f;
  logic [3:0]  vec;
  logic        busy, done, pass, fseen;
  logic [4:0]  err;
  logic [3:0]  fvec;

  assign dut_f = exp_tbl[vec] ^ (mode == 1) ^ ((mode == 2) && (vec == 4'd10));

  // 2-input, 1-clock hold instance
  logic [3:0]  exp_tbl2 = 4'b0110;
  logic        start2   = 1'b0;
  logic        dut2_f;
  logic [1:0]  vec2;
  logic        busy2, done2, pass2, fseen2;
  logic [2:0]  err2;
  logic [1:0]  fvec2;

  assign dut2_f = exp_tbl2[vec2];

`ifdef TT_SWEEP_CAPTURE_EN
  logic [15:0] captured;
  logic [3:0]  captured2;
`endif

  tt_sweep_checker #(.N_IN(4), .HOLD_CYCLES(20), .EXP_TABLE(16'hA5C3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dut_f_i     (dut_f),
    .vec_out_o   (vec),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err),
    .fail_vec_o  (fvec),
`ifdef TT_SWEEP_CAPTURE_EN
    .fail_seen_o (fseen),
    .captured_o  (captured)
`else
    .fail_seen_o (fseen)
`endif
  );

  tt_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1), .EXP_TABLE(4'b0110)) dut2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start2),
    .dut_f_i     (dut2_f),
    .vec_out_o   (vec2),
    .busy_o      (busy2),
    .done_o      (done2),
    .pass_o      (pass2),
    .err_count_o (err2),
    .fail_vec_o  (fvec2),
`ifdef TT_SWEEP_CAPTURE_EN
    .fail_seen_o (fseen2),
    .captured_o  (captured2)
`else
    .fail_seen_o (fseen2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts clocks from the start edge until done; checks the vector sequence on the way.
  // restart_at > 0 re-pulses start just before that edge to prove it is ignored.
  task automatic run_sweep(input int restart_at, output int lat, output int vec_bad);
    lat = -1;
    vec_bad = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k == restart_at) begin
        @(negedge clk);
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k < 320 && vec != 4'(k / 20)) vec_bad++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    int mode;
    int err;
    int fvec;
    int fseen;
    int pass;
  } case_t;

  case_t tbl[3];

  initial begin
    int lat, vbad, found;

    tbl[0] = '{mode: 0, err: 0,  fvec: 0,  fseen: 0, pass: 1};
    tbl[1] = '{mode: 1, err: 16, fvec: 0,  fseen: 1, pass: 0};
    tbl[2] = '{mode: 2, err: 1,  fvec: 10, fseen: 1, pass: 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({vec, busy, done, pass, err, fvec, fseen}), 0);
    check("reset_outputs2", int'({vec2, busy2, done2, pass2, err2, fvec2, fseen2}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      pulse_start();
      check("start_busy", int'(busy), 1);
      check("start_clears", int'({done, pass, err, fvec, fseen, vec}), 0);
`ifdef TT_SWEEP_CAPTURE_EN
      if (i > 0) check("captured_cleared", int'(captured), 0);
`endif
      run_sweep(0, lat, vbad);
      check("latency", lat, 320);
      check("vec_sequence", vbad, 0);
      check("err_count", int'(err), tbl[i].err);
      check("fail_vec", int'(fvec), tbl[i].fvec);
      check("fail_seen", int'(fseen), tbl[i].fseen);
      check("pass", int'(pass), tbl[i].pass);
      check("busy_end", int'(busy), 0);
`ifdef TT_SWEEP_CAPTURE_EN
      if (tbl[i].mode == 0) check("captured", int'(captured), 16'hA5C3);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("done_held_vec_parked", int'({done, vec}), 5'h1F);
    end

    // Abort mid-sweep, then a clean sweep must follow.
    mode = 0;
    pulse_start();
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (vec == 4'd5) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("reach_vec5", found, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_sweep", int'({vec, busy, done, pass, err, fvec, fseen}), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    run_sweep(0, lat, vbad);
    check("after_rst_latency", lat, 320);
    check("after_rst_result", int'({pass, err, fseen}), 7'b1000000);

    // start re-pulsed while vector 7 is on the bus.
    mode = 2;
    pulse_start();
    run_sweep(141, lat, vbad);
    check("busy_restart_latency", lat, 320);
    check("busy_restart_vecs", vbad, 0);
    check("busy_restart_err", int'(err), 1);

    // rst and start together: reset wins, nothing starts.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", int'({busy, done, err}), 0);
    @(posedge clk);
    #1;
    check("rst_beats_start_idle", int'(busy), 0);

    // 1-clock hold: one vector per clock, done four clocks after start.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("small_vec0", int'(vec2), 0);
    lat = -1;
    vbad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k < 4 && vec2 != 2'(k)) vbad++;
      if (done2) begin
        lat = k;
        break;
      end
    end
    check("small_latency", lat, 4);
    check("small_vecs", vbad, 0);
    check("small_result", int'({pass2, err2, vec2}), 6'b100011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
